pixel_output_buffer: RTL
========================

# pixel_output_buffer

Elastic colour buffer between the shader pipeline and the HDMI display timing logic. Absorbs the bursty, multi-cycle `color_valid` output of the shader and delivers one RGB pixel per display request with fixed one-cycle latency. Handles start-up priming, underrun substitution, overflow dropping and per-frame flush, and keeps saturating error counters for bring-up.

## Interface
Parameters:
- `DEPTH`, 16, FIFO entries (power of two)
- `ADDR_WIDTH`, 4, log2(DEPTH)
- `PREFILL`, 4, level required before streaming starts (1..DEPTH)
- `FALLBACK_RGB`, 24'h000000, colour emitted when no data is served ({R,G,B})

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous active-low reset
- `color_r`, `color_g`, `color_b`  in  8 each  shader colour
- `color_valid`  in  1  one-cycle push strobe
- `frame_start`  in  1  synchronous flush, one-cycle pulse
- `pixel_req`  in  1  display consumes one pixel this cycle
- `pix_r`, `pix_g`, `pix_b`  out  8 each  registered pixel
- `pix_valid`  out  1  pixel on `pix_*` answers the previous `pixel_req`
- `not_full`  out  1  advisory: level < DEPTH
- `level`  out  ADDR_WIDTH+1  current occupancy 0..DEPTH
- `overflow`  out  1  one-cycle pulse, push dropped
- `underflow`  out  1  one-cycle pulse, request served with fallback while streaming
- `drop_count`  out  16  saturating count of dropped pushes
- `underrun_count`  out  16  saturating count of underflows

## Operation
- FSM states: PRIME, STREAM. Reset and `frame_start` enter PRIME.
- PRIME: `pixel_req` returns FALLBACK_RGB, no pop, no `underflow`. Move to STREAM when `level` ≥ PREFILL (evaluated on registered level).
- STREAM: `pixel_req` with level > 0 pops head to `pix_*`. `pixel_req` with level == 0 returns FALLBACK_RGB, pulses `underflow`, increments `underrun_count`, returns to PRIME.
- Push: `color_valid` accepted if level < DEPTH, or if a pop occurs the same cycle. Otherwise dropped: `overflow` pulse, `drop_count` increments.
- Push and pop in the same cycle leave `level` unchanged. There is no bypass when empty: push+pop at level 0 in STREAM is an underflow, and the pushed word is stored.
- `frame_start` takes precedence over everything that cycle. Pointers and level clear, any simultaneous push and pop are discarded, state goes to PRIME, and `pix_valid` is asserted with FALLBACK_RGB if `pixel_req` was high. Counters are not cleared.
- Counters saturate at 16'hFFFF.
- Pointers wrap modulo DEPTH. `level` is a separate counter, not a pointer difference.

## Timing
- Reset values: `pix_*` = 0, `pix_valid` = 0, `overflow` = `underflow` = 0, `level` = 0, counters = 0, `not_full` = 1, state PRIME.
- `pix_valid` and `pix_*` update one cycle after `pixel_req`. `pix_valid` is low in cycles with no request, and `pix_*` hold their last value.
- `overflow`, `underflow` and counter updates are registered, visible the cycle after the causing event.
- Push-to-pop latency is at least one cycle: data written at edge N is poppable from edge N+1.
- Reset asserted mid-operation clears everything immediately; FIFO contents are considered invalid.

## Structure
- Shared package holds the FSM state encoding (PRIME=1'b0, STREAM=1'b1), colour width 8, and counter width 16.
- One sub-module, `pixel_fifo_mem`: DEPTH×24 storage with write/read pointers and registered read data. Level, FSM, fallback muxing and counters live in `pixel_output_buffer`.

## Test plan
- Reset, then `pixel_req` every cycle with no pushes → `pix_valid`=1 with 0x000000 each cycle, `underflow` never asserts, state stays PRIME.
- Push 4 colours (0x110000, 0x220000, 0x330000, 0x440000), then request 4 → output in order one cycle after each request, `level` 4→0.
- Continue requesting after those 4 with no pushes → one `underflow` pulse, `underrun_count`=1, FALLBACK output, return to PRIME.
- Push 17 colours with no requests (DEPTH=16) → `level`=16, one `overflow`, `drop_count`=1. Then push+pop together at full → push accepted, `level` stays 16, no overflow.
- `frame_start` coincident with push and `pixel_req` at level 8 → `level`=0, FALLBACK served, state PRIME, counters unchanged.
- Force `drop_count` toward 16'hFFFF with repeated overflow → holds at 16'hFFFF.

Source files
------------

// File: rtl/pixel_output_buffer_pkg.sv
// Shared definitions for the pixel output buffer: FSM encoding, colour and
// counter widths, and a saturating-increment helper for the error counters.
package pixel_output_buffer_pkg;

  localparam int COLOR_W = 8;
  localparam int PIX_W   = 3 * COLOR_W;
  localparam int CNT_W   = 16;

  // PRIME: waiting for the FIFO to reach its prefill level.
  // STREAM: serving pixels from the FIFO.
  typedef enum logic {
    PRIME  = 1'b0,
    STREAM = 1'b1
  } pob_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// DEPTH x 24-bit colour storage with wrapping write/read pointers and a
// registered read port. Occupancy tracking lives in the parent; this block
// trusts wr_en/rd_en to be legal.
module pixel_fifo_mem
  import pixel_output_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  output logic [PIX_W-1:0] rd_data
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [PIX_W-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  // Pointer update: clear wins, otherwise advance modulo DEPTH on each access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wr_ptr] <= wr_data;
  end

  // Registered read: the head word appears the cycle after rd_en and holds
  // until the next read. A same-cycle write to the head slot (full FIFO)
  // returns the old word because the array update is non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en && !clear) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/pixel_output_buffer.sv
// Elastic colour buffer between the shader and the display timing logic.
// Handshake: color_valid is a one-cycle push strobe with no back-pressure
// (not_full is advisory; pushes that find no room are dropped and counted);
// pixel_req consumes one pixel, answered by pix_valid/pix_* exactly one
// cycle later with either FIFO data or FALLBACK_RGB.
module pixel_output_buffer
  import pixel_output_buffer_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          ADDR_WIDTH   = 4,
  parameter int          PREFILL      = 4,
  parameter logic [23:0] FALLBACK_RGB = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            color_r,
  input  logic [7:0]            color_g,
  input  logic [7:0]            color_b,
  input  logic                  color_valid,
  input  logic                  frame_start,
  input  logic                  pixel_req,
  output logic [7:0]            pix_r,
  output logic [7:0]            pix_g,
  output logic [7:0]            pix_b,
  output logic                  pix_valid,
  output logic                  not_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           drop_count,
  output logic [15:0]           underrun_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PREFILL_L = (ADDR_WIDTH+1)'(PREFILL);
  localparam logic [ADDR_WIDTH:0] LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  pob_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                push, pop;
  logic                serve_fb;
  logic                overflow_d, underflow_d;
  logic                overflow_q, underflow_q;
  logic [CNT_W-1:0]    drop_q, underrun_q;
  logic                pix_valid_q;
  logic                src_fifo_q;
  logic [PIX_W-1:0]    fb_hold_q;
  logic [PIX_W-1:0]    fifo_rd_data;

  pixel_fifo_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (frame_start),
    .wr_en   (push),
    .wr_data ({color_r, color_g, color_b}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= PRIME;
    else        state_q <= state_d;
  end

  // Next state, pop/push decisions, fallback selection and level update.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    push        = 1'b0;
    pop         = 1'b0;
    serve_fb    = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (frame_start) begin
      // Flush: any push/pop this cycle is discarded, a request gets fallback.
      state_d  = PRIME;
      level_d  = '0;
      serve_fb = pixel_req;
    end else begin
      unique case (state_q)
        PRIME: begin
          serve_fb = pixel_req;
          if (level_q >= PREFILL_L) state_d = STREAM;
        end
        STREAM: begin
          if (pixel_req) begin
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              // No bypass: even a same-cycle push cannot satisfy this request.
              serve_fb    = 1'b1;
              underflow_d = 1'b1;
              state_d     = PRIME;
            end
          end
        end
        default: state_d = PRIME;
      endcase
      if (color_valid) begin
        if ((level_q < DEPTH_L) || pop) push = 1'b1;
        else                            overflow_d = 1'b1;
      end
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end
  end

  // Occupancy, event pulses and saturating error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drop_q      <= '0;
      underrun_q  <= '0;
    end else begin
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (overflow_d)  drop_q     <= sat_inc(drop_q);
      if (underflow_d) underrun_q <= sat_inc(underrun_q);
    end
  end

  // Output source tracking: pix_* shows either the FIFO read register or the
  // fallback hold register, and both hold their value between requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      src_fifo_q  <= 1'b0;
      fb_hold_q   <= '0;
    end else begin
      pix_valid_q <= pixel_req;
      if (pop) begin
        src_fifo_q <= 1'b1;
      end else if (serve_fb) begin
        src_fifo_q <= 1'b0;
        fb_hold_q  <= FALLBACK_RGB;
      end
    end
  end

  assign {pix_r, pix_g, pix_b} = src_fifo_q ? fifo_rd_data : fb_hold_q;
  assign pix_valid      = pix_valid_q;
  assign level          = level_q;
  assign not_full       = (level_q < DEPTH_L);
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;
  assign drop_count     = drop_q;
  assign underrun_count = underrun_q;

endmodule
